// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: default widths, the
// zero-register address and the packed WB pipeline register bundle.
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;
  localparam int WB_SEL_W  = 3;
  localparam int WB_NSRC   = 6;

  localparam logic [WB_ADDR_W-1:0] RF_ZERO_ADDR = '0;

  typedef struct packed {
    logic                 valid;
    logic                 rf_we;
    logic                 hi_we;
    logic                 lo_we;
    logic [WB_ADDR_W-1:0] rfaddr;
    logic [WB_DATA_W-1:0] rfdata;
    logic [WB_DATA_W-1:0] hi;
    logic [WB_DATA_W-1:0] lo;
  } wb_bundle_t;

endpackage

// File: rtl/wb_src_mux.sv
// Parametrised NSRC:1 source mux. Out-of-range selects yield zero data and
// raise oor_o, so callers can flag bad decode without X propagation.
module wb_src_mux #(
  parameter int DATA_W = 32,
  parameter int NSRC   = 6,
  parameter int SEL_W  = 3
) (
  input  logic [NSRC*DATA_W-1:0] src_bus_i,
  input  logic [SEL_W-1:0]       sel_i,
  output logic [DATA_W-1:0]      data_o,
  output logic                   oor_o
);

  logic [DATA_W-1:0] src_arr [NSRC];
  logic [NSRC-1:0]   hit_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      assign src_arr[gi] = src_bus_i[gi*DATA_W +: DATA_W];
      assign hit_vec[gi] = (sel_i == SEL_W'(gi));
    end
  endgenerate

  // One-hot AND-OR keeps the mux free of out-of-range array indexing.
  always_comb begin
    data_o = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (hit_vec[i]) data_o = data_o | src_arr[i];
    end
  end

  assign oor_o = ~(|hit_vec);

endmodule

// File: rtl/wb_writeback_unit.sv
// Registered writeback stage with RF source select, HI/LO ownership, ID-stage
// forwarding and sticky select-error. Optional retire counter: WB_RETIRE_CNT_EN.
module wb_writeback_unit
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int NSRC   = WB_NSRC,
  parameter int SEL_W  = WB_SEL_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   in_flush,
  input  logic [NSRC*DATA_W-1:0] in_src_bus,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic [ADDR_W-1:0]      in_rfaddr,
  input  logic                   in_rf_we,
  input  logic                   in_hi_we,
  input  logic                   in_lo_we,
  input  logic                   in_hi_sel,
  input  logic                   in_lo_sel,
  input  logic [DATA_W-1:0]      in_rs_hi,
  input  logic [DATA_W-1:0]      in_alu_hi,
  input  logic [DATA_W-1:0]      in_rs_lo,
  input  logic [DATA_W-1:0]      in_alu_lo,
  input  logic [ADDR_W-1:0]      rd_addr_a,
  input  logic [ADDR_W-1:0]      rd_addr_b,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  output logic [DATA_W-1:0]      hi_q,
  output logic [DATA_W-1:0]      lo_q,
  output logic [DATA_W-1:0]      hi_fwd,
  output logic [DATA_W-1:0]      lo_fwd,
  output logic                   fwd_hit_a,
  output logic                   fwd_hit_b,
  output logic                   sel_err
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]            retire_cnt
`endif
);

  logic [DATA_W-1:0] mux_data;
  logic              mux_oor;
  wb_bundle_t        wb_d;
  wb_bundle_t        wb_q;
  logic              sel_err_q;
  logic              sel_err_d;
  logic              capture;

  wb_src_mux #(
    .DATA_W (DATA_W),
    .NSRC   (NSRC),
    .SEL_W  (SEL_W)
  ) u_src_mux (
    .src_bus_i (in_src_bus),
    .sel_i     (in_sel),
    .data_o    (mux_data),
    .oor_o     (mux_oor)
  );

  assign capture = in_valid & ~in_flush;

  // Payload loads every cycle; only valid gates its architectural effect.
  always_comb begin
    wb_d        = '0;
    wb_d.valid  = capture;
    wb_d.rf_we  = in_rf_we;
    wb_d.hi_we  = in_hi_we;
    wb_d.lo_we  = in_lo_we;
    wb_d.rfaddr = in_rfaddr;
    wb_d.rfdata = mux_data;
    wb_d.hi     = in_hi_sel ? in_rs_hi : in_alu_hi;
    wb_d.lo     = in_lo_sel ? in_rs_lo : in_alu_lo;
  end

  assign sel_err_d = sel_err_q | (capture & mux_oor);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q      <= '0;
      sel_err_q <= 1'b0;
    end else begin
      wb_q      <= wb_d;
      sel_err_q <= sel_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (wb_q.valid && wb_q.hi_we) hi_q <= wb_q.hi;
      if (wb_q.valid && wb_q.lo_we) lo_q <= wb_q.lo;
    end
  end

  assign rf_we     = wb_q.valid & wb_q.rf_we & (wb_q.rfaddr != RF_ZERO_ADDR);
  assign rf_waddr  = wb_q.rfaddr;
  assign rf_wdata  = wb_q.rfdata;
  assign hi_fwd    = (wb_q.valid & wb_q.hi_we) ? wb_q.hi : hi_q;
  assign lo_fwd    = (wb_q.valid & wb_q.lo_we) ? wb_q.lo : lo_q;
  assign fwd_hit_a = rf_we & (rf_waddr == rd_addr_a);
  assign fwd_hit_b = rf_we & (rf_waddr == rd_addr_b);
  assign sel_err   = sel_err_q;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_q;
  logic [31:0] retire_d;

  assign retire_d = wb_q.valid ? retire_q + 32'd1 : retire_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retire_q <= '0;
    else        retire_q <= retire_d;
  end

  assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Randomised bench for wb_writeback_unit against a cycle-level reference model
// of the writeback rules; directed cases cover reset, r0, HI/LO, flush, sel_err.
module tb_wb_writeback_unit;

  localparam int DW = 32;
  localparam int NS = 6;
  localparam int SW = 3;
  localparam int AW = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid, in_flush;
  logic [NS*DW-1:0] in_src_bus;
  logic [SW-1:0]  in_sel;
  logic [AW-1:0]  in_rfaddr;
  logic           in_rf_we, in_hi_we, in_lo_we, in_hi_sel, in_lo_sel;
  logic [DW-1:0]  in_rs_hi, in_alu_hi, in_rs_lo, in_alu_lo;
  logic [AW-1:0]  rd_addr_a, rd_addr_b;
  logic           rf_we;
  logic [AW-1:0]  rf_waddr;
  logic [DW-1:0]  rf_wdata, hi_q, lo_q, hi_fwd, lo_fwd;
  logic           fwd_hit_a, fwd_hit_b, sel_err;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0]    retire_cnt;
`endif

  wb_writeback_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_flush(in_flush),
    .in_src_bus(in_src_bus), .in_sel(in_sel), .in_rfaddr(in_rfaddr),
    .in_rf_we(in_rf_we), .in_hi_we(in_hi_we), .in_lo_we(in_lo_we),
    .in_hi_sel(in_hi_sel), .in_lo_sel(in_lo_sel), .in_rs_hi(in_rs_hi),
    .in_alu_hi(in_alu_hi), .in_rs_lo(in_rs_lo), .in_alu_lo(in_alu_lo),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .hi_q(hi_q), .lo_q(lo_q),
    .hi_fwd(hi_fwd), .lo_fwd(lo_fwd), .fwd_hit_a(fwd_hit_a),
    .fwd_hit_b(fwd_hit_b), .sel_err(sel_err)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the instruction sitting in WB plus architectural state.
  bit          m_valid, m_rfwe, m_hiwe, m_lowe;
  int unsigned m_addr, m_data, m_hi, m_lo;
  int unsigned m_hiq, m_loq, m_cnt;
  bit          m_selerr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned pick_src(input logic [NS*DW-1:0] bus, input int sel);
    if (sel < NS) return bus[sel*DW +: DW];
    return 0;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_rfwe = 0; m_hiwe = 0; m_lowe = 0;
    m_addr = 0; m_data = 0; m_hi = 0; m_lo = 0;
    m_hiq = 0; m_loq = 0; m_cnt = 0; m_selerr = 0;
  endtask

  task automatic model_edge();
    bit cap;
    if (m_valid && m_hiwe) m_hiq = m_hi;
    if (m_valid && m_lowe) m_loq = m_lo;
    if (m_valid) m_cnt = m_cnt + 1;
    cap = in_valid && !in_flush;
    if (cap && int'(in_sel) >= NS) m_selerr = 1;
    m_valid = cap;
    m_rfwe  = in_rf_we;
    m_hiwe  = in_hi_we;
    m_lowe  = in_lo_we;
    m_addr  = in_rfaddr;
    m_data  = pick_src(in_src_bus, int'(in_sel));
    m_hi    = in_hi_sel ? in_rs_hi : in_alu_hi;
    m_lo    = in_lo_sel ? in_rs_lo : in_alu_lo;
  endtask

  task automatic check_all(input string ctx);
    bit ewe;
    ewe = m_valid && m_rfwe && (m_addr != 0);
    $display("[%0t] %s: rf_we=%0b addr=%0d data=%08h hi=%08h lo=%08h", $time, ctx,
             rf_we, rf_waddr, rf_wdata, hi_q, lo_q);
    chk({ctx, ".rf_we"}, 64'(rf_we), 64'(ewe));
    if (m_valid) begin
      chk({ctx, ".rf_waddr"}, 64'(rf_waddr), 64'(m_addr));
      chk({ctx, ".rf_wdata"}, 64'(rf_wdata), 64'(m_data));
    end
    chk({ctx, ".hi_q"}, 64'(hi_q), 64'(m_hiq));
    chk({ctx, ".lo_q"}, 64'(lo_q), 64'(m_loq));
    chk({ctx, ".hi_fwd"}, 64'(hi_fwd), 64'((m_valid && m_hiwe) ? m_hi : m_hiq));
    chk({ctx, ".lo_fwd"}, 64'(lo_fwd), 64'((m_valid && m_lowe) ? m_lo : m_loq));
    chk({ctx, ".hit_a"}, 64'(fwd_hit_a), 64'(ewe && (m_addr == int'(rd_addr_a))));
    chk({ctx, ".hit_b"}, 64'(fwd_hit_b), 64'(ewe && (m_addr == int'(rd_addr_b))));
    chk({ctx, ".sel_err"}, 64'(sel_err), 64'(m_selerr));
`ifdef WB_RETIRE_CNT_EN
    chk({ctx, ".retire"}, 64'(retire_cnt), 64'(m_cnt));
`endif
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_flush = 0; in_sel = 0; in_rfaddr = 0;
    in_rf_we = 0; in_hi_we = 0; in_lo_we = 0; in_hi_sel = 0; in_lo_sel = 0;
    in_rs_hi = 0; in_alu_hi = 0; in_rs_lo = 0; in_alu_lo = 0;
    for (int i = 0; i < NS; i++) in_src_bus[i*DW +: DW] = 32'h1000_0000 + i;
  endtask

  // Inputs were set at the preceding negedge; capture, then check at negedge.
  task automatic step(input string ctx);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(ctx);
  endtask

  task automatic check_zero(input string ctx);
    chk({ctx, ".rf_we"}, 64'(rf_we), 64'(0));
    chk({ctx, ".rf_waddr"}, 64'(rf_waddr), 64'(0));
    chk({ctx, ".rf_wdata"}, 64'(rf_wdata), 64'(0));
    chk({ctx, ".hi_q"}, 64'(hi_q), 64'(0));
    chk({ctx, ".lo_q"}, 64'(lo_q), 64'(0));
    chk({ctx, ".hi_fwd"}, 64'(hi_fwd), 64'(0));
    chk({ctx, ".lo_fwd"}, 64'(lo_fwd), 64'(0));
    chk({ctx, ".sel_err"}, 64'(sel_err), 64'(0));
`ifdef WB_RETIRE_CNT_EN
    chk({ctx, ".retire"}, 64'(retire_cnt), 64'(0));
`endif
  endtask

  initial begin
    int unsigned last_addr;
    idle_inputs();
    rd_addr_a = 0; rd_addr_b = 0;
    rst_n = 0;
    model_clear();
    #12;
    check_zero("reset");
    @(negedge clk); rst_n = 1;

    // Seed HI/LO and a valid write, then reset before it can retire.
    in_valid = 1; in_hi_we = 1; in_alu_hi = 32'hAAAA_0001;
    step("seed_hi");
    in_hi_we = 0; in_sel = 2; in_rfaddr = 5; in_rf_we = 1;
    @(posedge clk);
    model_edge();
    #1 rst_n = 0;
    model_clear();
    #1 check_zero("reset_mid");
    @(posedge clk); #1 check_zero("reset_held");
    @(negedge clk); idle_inputs(); rst_n = 1;
    step("after_reset");

    // Source 3 to r7 with forwarding.
    in_valid = 1; in_sel = 3; in_src_bus[3*DW +: DW] = 32'hDEADBEEF;
    in_rfaddr = 7; in_rf_we = 1; rd_addr_a = 7; rd_addr_b = 6;
    step("sel3_r7");
    chk("sel3.wdata", 64'(rf_wdata), 64'h0000_0000_DEAD_BEEF);
    chk("sel3.hit_a", 64'(fwd_hit_a), 64'(1));

    // r0 destination is suppressed.
    in_rfaddr = 0; rd_addr_a = 0;
    step("r0");
    chk("r0.rf_we", 64'(rf_we), 64'(0));
    chk("r0.hit_a", 64'(fwd_hit_a), 64'(0));

    // HI from rs, LO from ALU in the same cycle.
    in_rf_we = 0; in_hi_we = 1; in_lo_we = 1; in_hi_sel = 1; in_lo_sel = 0;
    in_rs_hi = 32'h11; in_alu_hi = 32'h99; in_rs_lo = 32'h88; in_alu_lo = 32'h22;
    step("hilo");
    chk("hilo.hi_fwd", 64'(hi_fwd), 64'h11);
    chk("hilo.lo_fwd", 64'(lo_fwd), 64'h22);
    idle_inputs();
    step("hilo_commit");
    chk("hilo.hi_q", 64'(hi_q), 64'h11);
    chk("hilo.lo_q", 64'(lo_q), 64'h22);

    // Flush wins over valid, even with a bad select.
    in_valid = 1; in_flush = 1; in_sel = 7; in_rfaddr = 9; in_rf_we = 1;
    step("flush");
    chk("flush.rf_we", 64'(rf_we), 64'(0));
    chk("flush.sel_err", 64'(sel_err), 64'(0));
    in_flush = 0;
    step("oor_sel");
    chk("oor.wdata", 64'(rf_wdata), 64'(0));
    chk("oor.sel_err", 64'(sel_err), 64'(1));
    idle_inputs();
    step("oor_sticky");
    chk("oor.sticky", 64'(sel_err), 64'(1));

`ifdef WB_RETIRE_CNT_EN
    force dut.retire_q = 32'hFFFF_FFFE;
    #1 release dut.retire_q;
    m_cnt = 32'hFFFF_FFFE;
    in_valid = 1; in_rfaddr = 3; in_rf_we = 1;
    step("cnt_a");
    step("cnt_b");
    chk("cnt.ff", 64'(retire_cnt), 64'hFFFF_FFFF);
    in_flush = 1;
    step("cnt_flush");
    chk("cnt.wrap", 64'(retire_cnt), 64'(0));
    in_flush = 0;
    step("cnt_c");
    chk("cnt.after_flush", 64'(retire_cnt), 64'(0));
    idle_inputs();
    step("cnt_idle");
    chk("cnt.one", 64'(retire_cnt), 64'(1));
`endif

    // Randomised traffic with one reset to clear the sticky flag.
    last_addr = 0;
    for (int c = 0; c < 400; c++) begin
      if (c == 150) begin
        rst_n = 0; model_clear();
        #1 check_zero("rand_reset");
        @(negedge clk); rst_n = 1;
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_flush  = ($urandom_range(0, 9) == 0);
      in_sel    = (c < 150 || $urandom_range(0, 7) == 0) ? SW'($urandom_range(0, 7))
                                                         : SW'($urandom_range(0, 5));
      in_rfaddr = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
      in_rf_we  = ($urandom_range(0, 4) != 0);
      in_hi_we  = $urandom_range(0, 1) != 0;
      in_lo_we  = $urandom_range(0, 1) != 0;
      in_hi_sel = $urandom_range(0, 1) != 0;
      in_lo_sel = $urandom_range(0, 1) != 0;
      in_rs_hi = $urandom; in_alu_hi = $urandom;
      in_rs_lo = $urandom; in_alu_lo = $urandom;
      for (int i = 0; i < NS; i++) in_src_bus[i*DW +: DW] = $urandom;
      rd_addr_a = ($urandom_range(0, 1) != 0) ? AW'(last_addr) : AW'($urandom);
      rd_addr_b = ($urandom_range(0, 2) == 0) ? AW'(last_addr) : AW'($urandom);
      last_addr = in_rfaddr;
      step($sformatf("rand%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
